// File: rtl/heap_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// heap_pkg
// Shared definitions for the heap access path: the heap action codes, the
// arbiter state encoding and a helper that tells which action codes the heap
// actually understands.
// No ports (package).
// ---------------------------------------------------------------------------
package heap_pkg;

    localparam int unsigned ACT_RESET = 1;
    localparam int unsigned ACT_ALLOC = 2;
    localparam int unsigned ACT_FREE  = 3;
    localparam int unsigned ACT_READ  = 4;
    localparam int unsigned ACT_WRITE = 5;
    localparam int unsigned ACT_SIZE  = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } heap_state_e;

    // Callers zero-extend their action field to 32 bits so the helper works
    // for any action width up to 32.
    function automatic logic is_legal_action(input logic [31:0] action);
        case (action)
            ACT_RESET, ACT_ALLOC, ACT_FREE,
            ACT_READ, ACT_WRITE, ACT_SIZE: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/heap_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: finds the first set request bit at or
// after the pointer, wrapping around the vector.
// Ports:
//   req   - request vector
//   ptr   - index where the circular search starts
//   grant - one-hot winner (all zero when no request)
//   idx   - binary index of the winner (0 when no request)
//   any   - at least one request is set
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Walk the requesters starting at ptr; the first hit wins and blocks
    // every later candidate through the found flag.
    always_comb begin
        logic        found;
        int unsigned cand;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(ptr) + i) % N;
            if (!found && req[IDX_W'(cand)]) begin
                found               = 1'b1;
                grant[IDX_W'(cand)] = 1'b1;
                idx                 = IDX_W'(cand);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/heap_arbiter.sv
// ---------------------------------------------------------------------------
// heap_arbiter
// Shares one heap memory between NUM_REQ instruction engines. One operation
// is in flight at a time: a round-robin winner is accepted, its fields are
// issued to the heap with a start pulse, and the heap result (or a timeout /
// illegal-action error) is returned only to that winner.
// Ports:
//   clock, reset           - system clock, synchronous active-high reset
//   req_valid / req_ready  - per-requester handshake (ready is a 1-cycle strobe)
//   req_action/array/index/wdata - packed per-requester operation fields
//   rsp_valid/data/error   - one-hot response strobe with shared result
//   heap_start             - 1-cycle start pulse to the heap
//   heap_action/array/index/wdata - registered operation fields to the heap
//   heap_done / heap_rdata - heap completion pulse and result
//   busy                   - arbiter is handling an operation
// ---------------------------------------------------------------------------
module heap_arbiter
    import heap_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ACTION_W = 8,
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 12,
    parameter int TIMEOUT  = 255
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*ACTION_W-1:0]  req_action,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_array,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_index,
    input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [DATA_W-1:0]            rsp_data,
    output logic                         rsp_error,
    output logic                         heap_start,
    output logic [ACTION_W-1:0]          heap_action,
    output logic [ADDR_W-1:0]            heap_array,
    output logic [ADDR_W-1:0]            heap_index,
    output logic [DATA_W-1:0]            heap_wdata,
    input  logic                         heap_done,
    input  logic [DATA_W-1:0]            heap_rdata,
    output logic                         busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    heap_state_e          state_q;
    logic [IDX_W-1:0]     rrPtr_q;
    logic [IDX_W-1:0]     winner_q;
    logic [CNT_W-1:0]     waitCnt_q;
    logic [NUM_REQ-1:0]   reqReady_q;
    logic [NUM_REQ-1:0]   rspValid_q;
    logic [DATA_W-1:0]    rspData_q;
    logic                 rspError_q;
    logic                 heapStart_q;
    logic [ACTION_W-1:0]  heapAction_q;
    logic [ADDR_W-1:0]    heapArray_q;
    logic [ADDR_W-1:0]    heapIndex_q;
    logic [DATA_W-1:0]    heapWdata_q;

    logic [NUM_REQ-1:0]   pickGrant;
    logic [IDX_W-1:0]     pickIdx;
    logic                 pickAny;
    logic [ACTION_W-1:0]  selAction;
    logic [ADDR_W-1:0]    selArray;
    logic [ADDR_W-1:0]    selIndex;
    logic [DATA_W-1:0]    selWdata;
    logic [NUM_REQ-1:0]   winnerOneHot;
    logic [IDX_W-1:0]     rrPtrNext;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (rrPtr_q),
        .grant (pickGrant),
        .idx   (pickIdx),
        .any   (pickAny)
    );

    // Pull the winning requester's fields out of the packed request buses.
    always_comb begin
        selAction = '0;
        selArray  = '0;
        selIndex  = '0;
        selWdata  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pickIdx == IDX_W'(i)) begin
                selAction = req_action[i*ACTION_W +: ACTION_W];
                selArray  = req_array[i*ADDR_W +: ADDR_W];
                selIndex  = req_index[i*ADDR_W +: ADDR_W];
                selWdata  = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Response strobe target and the pointer that makes the winner the
    // lowest priority for the next round.
    always_comb begin
        winnerOneHot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            winnerOneHot[i] = (winner_q == IDX_W'(i));
        end
        rrPtrNext = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + IDX_W'(1);
    end

    // Main FSM. All strobes default low each cycle so every pulse lasts
    // exactly one cycle. An illegal action is accepted but jumps straight to
    // RESP so the heap never sees it. In WAIT, heap_done is tested before the
    // timeout so a completion in the final allowed cycle still succeeds.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            rrPtr_q      <= '0;
            winner_q     <= '0;
            waitCnt_q    <= '0;
            reqReady_q   <= '0;
            rspValid_q   <= '0;
            rspData_q    <= '0;
            rspError_q   <= 1'b0;
            heapStart_q  <= 1'b0;
            heapAction_q <= '0;
            heapArray_q  <= '0;
            heapIndex_q  <= '0;
            heapWdata_q  <= '0;
        end else begin
            reqReady_q  <= '0;
            rspValid_q  <= '0;
            heapStart_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pickAny) begin
                        reqReady_q   <= pickGrant;
                        winner_q     <= pickIdx;
                        heapAction_q <= selAction;
                        heapArray_q  <= selArray;
                        heapIndex_q  <= selIndex;
                        heapWdata_q  <= selWdata;
                        if (is_legal_action(32'(selAction))) begin
                            heapStart_q <= 1'b1;
                            state_q     <= ISSUE;
                        end else begin
                            rspValid_q <= pickGrant;
                            rspData_q  <= '0;
                            rspError_q <= 1'b1;
                            state_q    <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    waitCnt_q <= '0;
                    state_q   <= WAIT;
                end
                WAIT: begin
                    if (heap_done) begin
                        rspValid_q <= winnerOneHot;
                        rspData_q  <= heap_rdata;
                        rspError_q <= 1'b0;
                        state_q    <= RESP;
                    end else if (waitCnt_q == CNT_W'(TIMEOUT - 1)) begin
                        rspValid_q <= winnerOneHot;
                        rspData_q  <= '0;
                        rspError_q <= 1'b1;
                        state_q    <= RESP;
                    end else begin
                        waitCnt_q <= waitCnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    rrPtr_q <= rrPtrNext;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready   = reqReady_q;
    assign rsp_valid   = rspValid_q;
    assign rsp_data    = rspData_q;
    assign rsp_error   = rspError_q;
    assign heap_start  = heapStart_q;
    assign heap_action = heapAction_q;
    assign heap_array  = heapArray_q;
    assign heap_index  = heapIndex_q;
    assign heap_wdata  = heapWdata_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_heap_arbiter.sv
// ---------------------------------------------------------------------------
// tb_heap_arbiter
// Self-checking bench for heap_arbiter. A transaction-level model keeps the
// pending requests, the round-robin pointer and the last accepted fields, and
// predicts each grant and response from the arbitration rules.
// ---------------------------------------------------------------------------
module tb_heap_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int XW = 12;
    localparam int DW = 12;
    localparam int TO = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_action;
    logic [N*XW-1:0]   req_array;
    logic [N*XW-1:0]   req_index;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              rsp_error;
    logic              heap_start;
    logic [AW-1:0]     heap_action;
    logic [XW-1:0]     heap_array;
    logic [XW-1:0]     heap_index;
    logic [DW-1:0]     heap_wdata;
    logic              heap_done;
    logic [DW-1:0]     heap_rdata;
    logic              busy;

    heap_arbiter #(
        .NUM_REQ  (N),
        .ACTION_W (AW),
        .ADDR_W   (XW),
        .DATA_W   (DW),
        .TIMEOUT  (TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_action  (req_action),
        .req_array   (req_array),
        .req_index   (req_index),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_error   (rsp_error),
        .heap_start  (heap_start),
        .heap_action (heap_action),
        .heap_array  (heap_array),
        .heap_index  (heap_index),
        .heap_wdata  (heap_wdata),
        .heap_done   (heap_done),
        .heap_rdata  (heap_rdata),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    // Reference model state
    int          rrPtr;
    bit          pendValid  [N];
    logic [AW-1:0] pendAction [N];
    logic [XW-1:0] pendArray  [N];
    logic [XW-1:0] pendIndex  [N];
    logic [DW-1:0] pendWdata  [N];
    logic [AW-1:0] lastAction;
    logic [XW-1:0] lastArray;
    logic [XW-1:0] lastIndex;
    logic [DW-1:0] lastWdata;

    int compared   = 0;
    int mismatched = 0;

    // Sample point: 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Put the model's pending requests on the request buses.
    task automatic applyStimulus();
        for (int i = 0; i < N; i++) begin
            req_valid[i]             = pendValid[i];
            req_action[i*AW +: AW]   = pendAction[i];
            req_array[i*XW +: XW]    = pendArray[i];
            req_index[i*XW +: XW]    = pendIndex[i];
            req_wdata[i*DW +: DW]    = pendWdata[i];
        end
    endtask

    task automatic postRequest(input int r, input logic [AW-1:0] act);
        pendValid[r]  = 1'b1;
        pendAction[r] = act;
        pendArray[r]  = XW'($urandom);
        pendIndex[r]  = XW'($urandom);
        pendWdata[r]  = DW'($urandom);
    endtask

    function automatic int modelWinner();
        for (int k = 0; k < N; k++) begin
            if (pendValid[(rrPtr + k) % N]) return (rrPtr + k) % N;
        end
        return -1;
    endfunction

    function automatic bit anyPending();
        for (int i = 0; i < N; i++) if (pendValid[i]) return 1'b1;
        return 1'b0;
    endfunction

    // One complete operation starting from an IDLE cycle. heapDelay is the
    // WAIT cycle (1 = cycle after start) in which heap_done pulses; 0 means
    // the heap never answers.
    task automatic runTxn(input int heapDelay, input logic [DW-1:0] heapData);
        int           w;
        bit           legal;
        bit           doneWins;
        int           endCycle;
        logic [N-1:0] oh;
        w = modelWinner();
        if (w < 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL runTxn: observed no pending request expected one");
            return;
        end
        oh    = '0;
        oh[w] = 1'b1;
        legal = (pendAction[w] >= 1) && (pendAction[w] <= 6);
        applyStimulus();
        tick();
        checkOutput("reqReady", req_ready, oh);
        checkOutput("heapStart", heap_start, legal);
        checkOutput("heapAction", heap_action, pendAction[w]);
        checkOutput("heapArray", heap_array, pendArray[w]);
        checkOutput("heapIndex", heap_index, pendIndex[w]);
        checkOutput("heapWdata", heap_wdata, pendWdata[w]);
        checkOutput("busyAccept", busy, 1);
        lastAction   = pendAction[w];
        lastArray    = pendArray[w];
        lastIndex    = pendIndex[w];
        lastWdata    = pendWdata[w];
        pendValid[w] = 1'b0;
        applyStimulus();
        if (legal) begin
            doneWins = (heapDelay >= 1) && (heapDelay <= TO);
            endCycle = doneWins ? heapDelay : TO;
            tick();
            for (int k = 1; k <= endCycle; k++) begin
                heap_done  = (k == heapDelay);
                heap_rdata = (k == heapDelay) ? heapData : DW'($urandom);
                checkOutput("waitRspValid", rsp_valid, 0);
                checkOutput("waitHeapStart", heap_start, 0);
                checkOutput("waitBusy", busy, 1);
                tick();
            end
            heap_done = 1'b0;
            checkOutput("rspValid", rsp_valid, oh);
            checkOutput("rspData", rsp_data, doneWins ? heapData : '0);
            checkOutput("rspError", rsp_error, !doneWins);
        end else begin
            checkOutput("illegalRspValid", rsp_valid, oh);
            checkOutput("illegalRspData", rsp_data, 0);
            checkOutput("illegalRspError", rsp_error, 1);
        end
        rrPtr = (w + 1) % N;
        tick();
        checkOutput("idleRspValid", rsp_valid, 0);
        checkOutput("idleReqReady", req_ready, 0);
        checkOutput("idleHeapStart", heap_start, 0);
        checkOutput("idleBusy", busy, 0);
        checkOutput("holdAction", heap_action, lastAction);
        checkOutput("holdArray", heap_array, lastArray);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "ReqReady"}, req_ready, 0);
        checkOutput({tag, "RspValid"}, rsp_valid, 0);
        checkOutput({tag, "RspData"}, rsp_data, 0);
        checkOutput({tag, "RspError"}, rsp_error, 0);
        checkOutput({tag, "HeapStart"}, heap_start, 0);
        checkOutput({tag, "HeapAction"}, heap_action, 0);
        checkOutput({tag, "HeapArray"}, heap_array, 0);
        checkOutput({tag, "HeapIndex"}, heap_index, 0);
        checkOutput({tag, "HeapWdata"}, heap_wdata, 0);
        checkOutput({tag, "Busy"}, busy, 0);
    endtask

    // Expect silence (no response, no grant) for a few cycles.
    task automatic checkQuiet(input string tag, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            checkOutput(tag, rsp_valid, 0);
            tick();
        end
    endtask

    initial begin
        int r;
        int act;
        reset      = 1'b1;
        heap_done  = 1'b0;
        heap_rdata = '0;
        rrPtr      = 0;
        for (int i = 0; i < N; i++) begin
            pendValid[i]  = 1'b0;
            pendAction[i] = '0;
            pendArray[i]  = '0;
            pendIndex[i]  = '0;
            pendWdata[i]  = '0;
        end
        lastAction = '0;
        lastArray  = '0;
        lastIndex  = '0;
        lastWdata  = '0;
        applyStimulus();
        tick();
        tick();
        checkAllZero("reset");
        reset = 1'b0;
        tick();

        // Contention: everyone valid, heap answers at once -> 0,1,2,3,0
        for (int i = 0; i < N; i++) postRequest(i, AW'($urandom_range(1, 6)));
        for (int g = 0; g < 5; g++) begin
            int w;
            w = modelWinner();
            runTxn(1, DW'($urandom));
            if (g < 4) postRequest(w, AW'($urandom_range(1, 6)));
        end
        while (anyPending()) runTxn(1, DW'($urandom));

        // Single requester ALLOC, heap answers 2 cycles after start with 5
        postRequest(0, 8'd2);
        runTxn(2, 12'd5);

        // Timeout on req1, then a stray heap_done must be ignored
        postRequest(1, 8'd4);
        runTxn(0, 12'h0);
        heap_done  = 1'b1;
        heap_rdata = 12'h7A5;
        tick();
        heap_done = 1'b0;
        checkOutput("strayBusy", busy, 0);
        checkQuiet("strayRspValid", 3);

        // Illegal action 9 from req2
        postRequest(2, 8'd9);
        runTxn(1, 12'h0);

        // Done and timeout coinciding on the last WAIT cycle: done wins
        postRequest(3, 8'd5);
        runTxn(TO, 12'hABC);

        // Serve req1 so the pointer moves to 2, then abandon req2 mid-WAIT
        postRequest(1, 8'd3);
        runTxn(1, DW'($urandom));
        postRequest(2, 8'd4);
        applyStimulus();
        tick();
        checkOutput("abortReqReady", req_ready, 4'b0100);
        pendValid[2] = 1'b0;
        applyStimulus();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rrPtr = 0;
        lastAction = '0;
        lastArray  = '0;
        checkAllZero("midReset");
        heap_done  = 1'b1;
        heap_rdata = 12'h123;
        tick();
        heap_done = 1'b0;
        checkQuiet("lateDoneRspValid", 3);
        // Pointer must be back at 0: req1 beats req3
        postRequest(1, 8'd6);
        postRequest(3, 8'd1);
        runTxn(1, DW'($urandom));
        runTxn(3, DW'($urandom));

        // Randomised traffic, including illegal codes and heap timeouts
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!pendValid[i] && ($urandom_range(0, 1) == 1)) begin
                    r   = $urandom_range(0, 9);
                    act = (r < 8) ? r : ((r == 8) ? 9 : 255);
                    postRequest(i, AW'(act));
                end
            end
            if (!anyPending()) postRequest($urandom_range(0, N - 1), AW'($urandom_range(1, 6)));
            runTxn($urandom_range(0, TO + 2), DW'($urandom));
        end
        while (anyPending()) runTxn($urandom_range(0, TO + 2), DW'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/heap_arbiter.md
Name: heap_arbiter

Overview:
- Shares the single heap memory (array allocator/store) between NUM_REQ independent instruction engines.
- Requesters present heap operations (reset, allocate, free, read, write, size) on a valid/ready port. The arbiter picks one round-robin, issues it to the heap and waits for completion.
- Returns the result or a timeout error to the winning requester only.
- Sits between the fpga program engines and the heap memory instance; it is the only driver of the heap's action port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ACTION_W, 8, heap action code width
- ADDR_W, 12, array-id and index width
- DATA_W, 12, data word width
- TIMEOUT, 255, maximum cycles to wait for heap_done before aborting

Ports:
- clock  in  1  single system clock, rising edge only
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester operation valid
- req_ready  out  NUM_REQ  one-hot accept strobe, one cycle
- req_action  in  NUM_REQ*ACTION_W  packed action codes
- req_array  in  NUM_REQ*ADDR_W  packed array ids
- req_index  in  NUM_REQ*ADDR_W  packed element indices
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- rsp_valid  out  NUM_REQ  one-hot response strobe, one cycle
- rsp_data  out  DATA_W  result word, valid with rsp_valid
- rsp_error  out  1  timeout or illegal action, valid with rsp_valid
- heap_start  out  1  one-cycle start pulse to heap
- heap_action, heap_array, heap_index, heap_wdata  out  ACTION_W/ADDR_W/ADDR_W/DATA_W  registered operation fields
- heap_done  in  1  heap completion pulse
- heap_rdata  in  DATA_W  heap result, valid with heap_done
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, rr_ptr=0, all outputs 0, timeout counter 0.
  - Reset asserted mid-operation abandons the transaction: no rsp_valid is issued, and heap_done arriving later is ignored.
- IDLE:
  - If any req_valid is set, select the first set bit at or after rr_ptr, searching circularly.
  - Assert req_ready[winner] for exactly one cycle, latch its fields into heap_* registers, latch winner id, go to ISSUE.
- Action legality:
  - Legal codes are 1..6.
  - An illegal code is still accepted, but skips the heap: next state is RESP with rsp_error=1 and rsp_data=0.
- ISSUE: heap_start=1 for exactly one cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - Count cycles.
  - On heap_done: capture heap_rdata; go to RESP with error=0.
  - If the count reaches TIMEOUT without heap_done: go to RESP with error=1, data=0.
  - heap_done and timeout in the same cycle: done wins.
- RESP:
  - rsp_valid[winner]=1 for one cycle with rsp_data/rsp_error.
  - rr_ptr = (winner+1) mod NUM_REQ.
  - Return to IDLE.
- Latency and throughput:
  - Minimum latency from accept to response is 3 cycles when the heap answers with done in the cycle after start.
  - Throughput is one operation in flight; no new grant is issued until RESP has completed.
- Stray heap_done pulses while in IDLE, ISSUE or RESP are ignored.
- Requesters hold valid and fields stable until they see req_ready. Fields changed before ready are undefined use.
- heap_* field outputs hold their values from accept until the next accept.
- Fairness: any continuously asserted request is granted within NUM_REQ grants.

Decomposition:
- Shared package heap_pkg:
  - action code constants: ACT_RESET=1, ACT_ALLOC=2, ACT_FREE=3, ACT_READ=4, ACT_WRITE=5, ACT_SIZE=6
  - state enum typedef: IDLE, ISSUE, WAIT, RESP
  - function is_legal_action
- One sub-module, rr_pick:
  - combinational round-robin selector (req vector, pointer → one-hot grant plus index).
  - Reused by other shared-resource arbiters.

Test Plan:
- Single requester: req0 ALLOC (action=2), heap_done with rdata=5 two cycles after start → req_ready[0] once, heap_start once, rsp_valid[0] with rsp_data=5, rsp_error=0.
- Contention: all four requesters valid continuously, heap answers immediately → grant order 0,1,2,3,0. No requester gets a second grant before the others have each had one.
- Timeout: heap_done never asserted → rsp_valid on the winner exactly TIMEOUT cycles after WAIT entry, rsp_error=1, rsp_data=0; a later stray heap_done produces no response.
- Illegal action 9 from req2 → accepted, heap_start never pulses, rsp_valid[2] with rsp_error=1.
- Reset during WAIT → next cycle busy=0, all outputs 0, rr_ptr=0. A following heap_done produces no rsp_valid, and the next request from req1 is served normally.
- Done/timeout coincidence: TIMEOUT=4 with heap_done on the 4th WAIT cycle → rsp_error=0, rsp_data=heap_rdata.
